uart_stim_tx: RTL and testbench
===============================

# uart_stim_tx

Parametrised, synthesizable UART transmit stimulus engine for the uDMA UART verification environment. It replaces the fixed-format, single-character `send_char` behavioural model with a clocked generator that accepts characters over a valid/ready handshake and buffers them in a FIFO. It serialises each character onto the DUT's `uart_rx_i` pin with runtime-selectable baud divider, data bits, parity and stop bits. Benches instantiate it between the sequencer and the `udma_uart_top` RX pin.

## Interface
- `FIFO_DEPTH`, 16 — character buffer entries; power of two, ≥2.
- `DIV_WIDTH`, 16 — width of baud divider.
- `sys_clk_i` in 1 — sole clock; all logic on rising edge.
- `rst_i` in 1 — reset, synchronous, active-high.
- `cfg_en_i` in 1 — 1: frames may start; 0: current frame completes, no new frame starts.
- `cfg_div_i` in DIV_WIDTH — bit period = `cfg_div_i`+1 clocks.
- `cfg_bits_i` in 2 — data bits: 0→5, 1→6, 2→7, 3→8.
- `cfg_parity_i` in 2 — 0/1 none, 2 even, 3 odd.
- `cfg_stop2_i` in 1 — 0: one stop bit, 1: two.
- `cfg_clr_i` in 1 — one-cycle flush of FIFO contents; the frame in flight is unaffected.
- `char_valid_i` in 1, `char_ready_o` out 1, `char_data_i` in 8 — push handshake.
- `char_perr_i`, `char_ferr_i` in 1 — per-character error-inject flags; see Configuration.
- `tx_o` out 1 — serial line to the DUT; idle high.
- `busy_o` out 1 — frame in progress.
- `frame_done_o` out 1 — one-cycle pulse at the end of the last stop bit.
- `fifo_level_o` out $clog2(FIFO_DEPTH)+1 — occupied entries.

## Operation
- FIFO stores {ferr, perr, data[7:0]}. A push occurs on an edge where `char_valid_i && char_ready_o`. `char_ready_o` = level < FIFO_DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: if `cfg_en_i` and FIFO is non-empty, pop the head. On the same edge, latch div/bits/parity/stop2 into frame registers, drive `tx_o`←0, and go to START. Config changes mid-frame have no effect until the next frame.
- Every non-IDLE state lasts div+1 clocks, counted by a down-counter reloaded on each state entry.
- START→DATA. DATA shifts out LSB first for the latched bit count (5–8), then goes to PARITY if parity is enabled, otherwise STOP1.
- Parity bit is the XOR of the transmitted data bits only: even mode sends XOR, odd mode sends ~XOR.
- STOP1 drives 1, then goes to STOP2 if two stop bits are latched, otherwise ends. STOP2 drives 1, then ends.
- End of frame: `frame_done_o` pulses. On that same edge the FSM may pop the next character directly (back-to-back frames, no idle bit), or return to IDLE.
- Push and pop on the same edge: level unchanged. A push when full is impossible because ready is low; a pop frees the slot, and ready rises the following cycle.
- `cfg_clr_i` with a simultaneous push: clear wins, and the pushed character is discarded.
- Pointers wrap modulo FIFO_DEPTH. Level saturates at neither end because the handshake prevents overflow and underflow.

## Timing
- Reset values: `tx_o`=1, `busy_o`=0, `frame_done_o`=0, `char_ready_o`=1, `fifo_level_o`=0. The FSM is in IDLE with an empty FIFO.
- Reset asserted mid-frame: `tx_o` returns to 1 on the next edge and the FIFO is flushed. No `frame_done_o` pulse is produced.
- Latency: a character pushed at edge N into an empty FIFO with the FSM idle is popped at edge N+1, and `tx_o` falls after N+1.
- Frame length in clocks: (div+1)·(1 + bits + parity?1:0 + stop2?2:1).
- `busy_o` is high from the pop edge until the edge on which `frame_done_o` is asserted. It stays high across back-to-back frames.
- `tx_o` is registered and glitch-free.

## Configuration
- `UART_STIM_ERR_INJ_EN` defined:
  - `char_perr_i`=1 inverts that character's parity bit. It has no effect when parity is disabled.
  - `char_ferr_i`=1 drives STOP1 low (framing error); STOP2, if enabled, stays high.
- Undefined: the flags are not stored (FIFO width 8), the inputs are ignored, and frames are always well formed.

## Test plan
- div=3, 8N1, push 0x15: `tx_o` holds 0 for 4 clocks, then data bits 1,0,1,0,1,0,0,0 for 4 clocks each, then stop 1. `frame_done_o` pulses 40 clocks after the pop.
- div=1, 8 bits, even parity, push 0x56 then 0x57: parity bits 0 then 1. The frames run back to back with no idle gap and `busy_o` stays high throughout. Repeat in odd mode: parity bits 1 then 0.
- cfg_bits=2 (7 bits), two stop bits, push 0xFF: bit 7 is not sent, and the frame is 1+7+2=10 bit periods.
- FIFO_DEPTH=4, `cfg_en_i`=0, push 5 characters: `char_ready_o` drops after 4 and `fifo_level_o`=4. Assert `cfg_en_i`: after the first pop `char_ready_o` rises and the fifth character is accepted. All 5 frames are transmitted in order.
- Assert `rst_i` mid-DATA of the second of three queued characters: `tx_o`=1 next edge, `fifo_level_o`=0, and no `frame_done_o` pulse. After release, the line stays idle.
- With `UART_STIM_ERR_INJ_EN`, even parity, push 0x56 with perr=1, then 0x56 with ferr=1: first parity bit is 1; second frame has STOP1=0. The DUT raises `err_event_o` for each frame.

Source files
------------

// File: rtl/uart_stim_tx.sv
// UART transmit stimulus engine: FIFO-buffered characters serialised with a runtime baud divider and frame format.
// Define UART_STIM_ERR_INJ_EN to store and honour per-character parity/framing error-inject flags.
module uart_stim_tx #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                            sys_clk_i,
    input  logic                            rst_i,
    input  logic                            cfg_en_i,
    input  logic [DIV_WIDTH-1:0]            cfg_div_i,
    input  logic [1:0]                      cfg_bits_i,
    input  logic [1:0]                      cfg_parity_i,
    input  logic                            cfg_stop2_i,
    input  logic                            cfg_clr_i,
    input  logic                            char_valid_i,
    output logic                            char_ready_o,
    input  logic [7:0]                      char_data_i,
    input  logic                            char_perr_i,
    input  logic                            char_ferr_i,
    output logic                            tx_o,
    output logic                            busy_o,
    output logic                            frame_done_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
`ifdef UART_STIM_ERR_INJ_EN
    localparam int FW = 10;
`else
    localparam int FW = 8;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP1, STOP2} state_t;

    // Parity over the transmitted bits only; odd mode and error injection each invert it.
    function automatic logic parity_bit(input logic [7:0] d, input logic [1:0] bits,
                                        input logic [1:0] mode, input logic inv);
        logic [7:0] mask;
        mask = 8'hFF >> (2'd3 - bits);
        return (^(d & mask)) ^ mode[0] ^ inv;
    endfunction

    logic [FW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        level;
    logic [FW-1:0]        head;
    logic [7:0]           head_data;
    logic                 head_perr, head_ferr;
    logic                 push, pop;

    state_t               state;
    logic [DIV_WIDTH-1:0] cnt, div_f;
    logic [2:0]           bits_left;
    logic [1:0]           bits_f;
    logic                 par_en_f, par_bit_f, stop2_f, stop1_bit_f;
    logic [7:0]           shreg;
    logic                 frame_end, shift;

    assign head      = mem[rd_ptr];
    assign head_data = head[7:0];
`ifdef UART_STIM_ERR_INJ_EN
    assign head_perr = head[8];
    assign head_ferr = head[9];
`else
    logic unused_flags;
    assign unused_flags = char_perr_i ^ char_ferr_i;
    assign head_perr    = 1'b0;
    assign head_ferr    = 1'b0;
`endif

    assign char_ready_o = level < DEPTH_L;
    assign fifo_level_o = level;
    // Clear beats a coincident push and suppresses any pop on the same edge.
    assign push = char_valid_i && char_ready_o && !cfg_clr_i;

    assign frame_end = (cnt == '0) && ((state == STOP1 && !stop2_f) || state == STOP2);
    assign pop       = cfg_en_i && (level != '0) && !cfg_clr_i && (state == IDLE || frame_end);
    assign shift     = (cnt == '0) && (state == START || (state == DATA && bits_left != 3'd0));

    always_ff @(posedge sys_clk_i) begin
        if (push) begin
`ifdef UART_STIM_ERR_INJ_EN
            mem[wr_ptr] <= {char_ferr_i, char_perr_i, char_data_i};
`else
            mem[wr_ptr] <= char_data_i;
`endif
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i || cfg_clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Frame registers capture the format at pop so mid-frame config changes are ignored.
    always_ff @(posedge sys_clk_i) begin
        if (pop) begin
            shreg       <= head_data;
            div_f       <= cfg_div_i;
            bits_f      <= cfg_bits_i;
            par_en_f    <= cfg_parity_i[1];
            par_bit_f   <= parity_bit(head_data, cfg_bits_i, cfg_parity_i, head_perr);
            stop2_f     <= cfg_stop2_i;
            stop1_bit_f <= ~head_ferr;
        end else if (shift) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            bits_left    <= 3'd0;
            tx_o         <= 1'b1;
            busy_o       <= 1'b0;
            frame_done_o <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            if (frame_end) begin
                frame_done_o <= 1'b1;
                if (pop) begin
                    state <= START;
                    cnt   <= cfg_div_i;
                    tx_o  <= 1'b0;
                end else begin
                    state  <= IDLE;
                    tx_o   <= 1'b1;
                    busy_o <= 1'b0;
                end
            end else if (state != IDLE && cnt != '0) begin
                cnt <= cnt - DIV_WIDTH'(1);
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            state  <= START;
                            cnt    <= cfg_div_i;
                            tx_o   <= 1'b0;
                            busy_o <= 1'b1;
                        end
                    end
                    START: begin
                        state     <= DATA;
                        cnt       <= div_f;
                        tx_o      <= shreg[0];
                        bits_left <= 3'd4 + {1'b0, bits_f};
                    end
                    DATA: begin
                        cnt <= div_f;
                        if (bits_left != 3'd0) begin
                            tx_o      <= shreg[0];
                            bits_left <= bits_left - 3'd1;
                        end else if (par_en_f) begin
                            state <= PARITY;
                            tx_o  <= par_bit_f;
                        end else begin
                            state <= STOP1;
                            tx_o  <= stop1_bit_f;
                        end
                    end
                    PARITY: begin
                        state <= STOP1;
                        cnt   <= div_f;
                        tx_o  <= stop1_bit_f;
                    end
                    STOP1: begin
                        state <= STOP2;
                        cnt   <= div_f;
                        tx_o  <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx_o  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_stim_tx.sv
// Self-checking bench for uart_stim_tx: queued expected frames are decoded bit-by-bit from tx_o.
module tb_uart_stim_tx;
    localparam int DEPTH = 4;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_en = 1'b0;
    logic [DW-1:0] cfg_div = '0;
    logic [1:0]    cfg_bits = 2'd3;
    logic [1:0]    cfg_parity = 2'd0;
    logic          cfg_stop2 = 1'b0;
    logic          cfg_clr = 1'b0;
    logic          char_valid = 1'b0;
    logic          char_ready;
    logic [7:0]    char_data = '0;
    logic          char_perr = 1'b0;
    logic          char_ferr = 1'b0;
    logic          tx, busy, frame_done;
    logic [$clog2(DEPTH):0] level;

    uart_stim_tx #(.FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
        .sys_clk_i(clk), .rst_i(rst), .cfg_en_i(cfg_en), .cfg_div_i(cfg_div),
        .cfg_bits_i(cfg_bits), .cfg_parity_i(cfg_parity), .cfg_stop2_i(cfg_stop2),
        .cfg_clr_i(cfg_clr), .char_valid_i(char_valid), .char_ready_o(char_ready),
        .char_data_i(char_data), .char_perr_i(char_perr), .char_ferr_i(char_ferr),
        .tx_o(tx), .busy_o(busy), .frame_done_o(frame_done), .fifo_level_o(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        int         nbits;
        int         par;
        bit         stop2;
        int         div;
        bit         perr;
        bit         ferr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   frames_seen = 0;
    bit   mon_abort = 1'b0;

    // Scoreboard: on each start bit pop the expected frame and check every clock of it.
    initial begin : scoreboard
        exp_t       e;
        logic [12:0] fb;
        int          nb, per, bad;
        logic        p;
        @(negedge clk);
        forever begin
            if (!mon_abort && tx === 1'b0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_start: tx=%b with empty scoreboard at %0t", tx, $time);
                    while (tx === 1'b0) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    fb = '0;
                    fb[0] = 1'b0;
                    p = 1'b0;
                    for (int i = 0; i < e.nbits; i++) begin
                        fb[1+i] = e.data[i];
                        p = p ^ e.data[i];
                    end
                    nb = 1 + e.nbits;
                    if (e.par >= 2) begin
                        fb[nb] = p ^ (e.par == 3) ^ e.perr;
                        nb++;
                    end
                    fb[nb] = ~e.ferr;
                    nb++;
                    if (e.stop2) begin
                        fb[nb] = 1'b1;
                        nb++;
                    end
                    per = e.div + 1;
                    bad = 0;
                    for (int s = 0; s < nb * per; s++) begin
                        if (s != 0) @(negedge clk);
                        if (mon_abort) break;
                        if (tx !== fb[s/per] || busy !== 1'b1) bad++;
                    end
                    if (!mon_abort) begin
                        n_cmp++;
                        if (bad != 0) begin
                            n_err++;
                            $display("FAIL frame_bits data=%h: %0d bad samples, required 0 (expected bits %b, lsb=start)",
                                     e.data, bad, fb);
                        end
                        @(negedge clk);
                        n_cmp++;
                        if (frame_done !== 1'b1) begin
                            n_err++;
                            $display("FAIL frame_done data=%h: got %b, required 1", e.data, frame_done);
                        end
                        frames_seen++;
                        continue;
                    end
                end
            end
            @(negedge clk);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_char(input logic [7:0] d, input bit pe, input bit fe);
        exp_t e;
        int   t = 0;
        @(negedge clk);
        char_valid = 1'b1;
        char_data  = d;
        char_perr  = pe;
        char_ferr  = fe;
        while (char_ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) begin
            n_cmp++; n_err++;
            $display("FAIL push_timeout data=%h: ready=%b, required 1", d, char_ready);
        end else begin
            @(posedge clk);
            e.data  = d;
            e.nbits = int'(cfg_bits) + 5;
            e.par   = int'(cfg_parity);
            e.stop2 = cfg_stop2;
            e.div   = int'(cfg_div);
`ifdef UART_STIM_ERR_INJ_EN
            e.perr  = pe;
            e.ferr  = fe;
`else
            e.perr  = 1'b0;
            e.ferr  = 1'b0;
`endif
            exp_q.push_back(e);
        end
        #1;
        char_valid = 1'b0;
        char_perr  = 1'b0;
        char_ferr  = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int t = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && t < limit) begin
            @(negedge clk);
            t++;
        end
        if (t >= limit) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: queue=%0d busy=%b, required 0/0", exp_q.size(), busy);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (tx !== 1'b1)         begin n_err++; $display("FAIL reset_tx: got %b, required 1", tx); end
        n_cmp++; if (busy !== 1'b0)       begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
        n_cmp++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b, required 0", frame_done); end
        n_cmp++; if (char_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b, required 1", char_ready); end
        n_cmp++; if (level !== '0)        begin n_err++; $display("FAIL reset_level: got %0d, required 0", level); end
    endtask

    task automatic test_basic_8n1();
        int base = frames_seen;
        cfg_en = 1'b1; cfg_div = 16'd3; cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        push_char(8'h15, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (level !== 3'd1 || tx !== 1'b1) begin
            n_err++; $display("FAIL latency_pre: level=%0d tx=%b, required 1/1", level, tx);
        end
        @(negedge clk);
        n_cmp++; if (level !== 3'd0 || tx !== 1'b0 || busy !== 1'b1) begin
            n_err++; $display("FAIL latency_pop: level=%0d tx=%b busy=%b, required 0/0/1", level, tx, busy);
        end
        wait_idle(500);
        n_cmp++; if (frames_seen - base !== 1) begin
            n_err++; $display("FAIL basic_frames: got %0d, required 1", frames_seen - base);
        end
    endtask

    task automatic test_parity_back_to_back(input logic [1:0] mode);
        int base = frames_seen;
        int busy_clks = 0;
        int t = 0;
        cfg_en = 1'b1; cfg_div = 16'd1; cfg_bits = 2'd3; cfg_parity = mode; cfg_stop2 = 1'b0;
        fork
            begin
                push_char(8'h56, 1'b0, 1'b0);
                push_char(8'h57, 1'b0, 1'b0);
            end
            begin
                while (busy !== 1'b1 && t < 200) begin @(negedge clk); t++; end
                while (busy === 1'b1 && busy_clks < 500) begin @(negedge clk); busy_clks++; end
            end
        join
        wait_idle(500);
        n_cmp++; if (busy_clks !== 44) begin
            n_err++; $display("FAIL b2b_busy mode=%0d: busy high %0d clocks, required 44", mode, busy_clks);
        end
        n_cmp++; if (frames_seen - base !== 2) begin
            n_err++; $display("FAIL parity_frames mode=%0d: got %0d, required 2", mode, frames_seen - base);
        end
    endtask

    task automatic test_7bit_2stop();
        int base = frames_seen;
        cfg_en = 1'b1; cfg_div = 16'd2; cfg_bits = 2'd2; cfg_parity = 2'd0; cfg_stop2 = 1'b1;
        push_char(8'hFF, 1'b0, 1'b0);
        push_char(8'h80, 1'b0, 1'b0);
        wait_idle(500);
        n_cmp++; if (frames_seen - base !== 2) begin
            n_err++; $display("FAIL 7bit_frames: got %0d, required 2", frames_seen - base);
        end
        cfg_stop2 = 1'b0;
    endtask

    task automatic test_fifo_full();
        int base = frames_seen;
        logic [7:0] chars [5];
        chars[0] = 8'hA1; chars[1] = 8'h3C; chars[2] = 8'h00; chars[3] = 8'hFE; chars[4] = 8'h5A;
        cfg_en = 1'b0; cfg_div = 16'd0; cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        for (int i = 0; i < 4; i++) push_char(chars[i], 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (char_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b, required 0", char_ready); end
        n_cmp++; if (level !== 3'd4)      begin n_err++; $display("FAIL full_level: got %0d, required 4", level); end
        cfg_en = 1'b1;
        @(negedge clk);
        n_cmp++; if (char_ready !== 1'b1 || level !== 3'd3) begin
            n_err++; $display("FAIL ready_after_pop: ready=%b level=%0d, required 1/3", char_ready, level);
        end
        push_char(chars[4], 1'b0, 1'b0);
        wait_idle(1000);
        n_cmp++; if (frames_seen - base !== 5) begin
            n_err++; $display("FAIL full_frames: got %0d, required 5", frames_seen - base);
        end
    endtask

    task automatic test_clear();
        int base = frames_seen;
        cfg_en = 1'b0; cfg_div = 16'd0; cfg_bits = 2'd3; cfg_parity = 2'd0;
        push_char(8'h11, 1'b0, 1'b0);
        push_char(8'h22, 1'b0, 1'b0);
        @(negedge clk);
        char_valid = 1'b1; char_data = 8'h33; cfg_clr = 1'b1;
        @(negedge clk);
        char_valid = 1'b0; cfg_clr = 1'b0;
        exp_q.delete();
        n_cmp++; if (level !== 3'd0 || char_ready !== 1'b1) begin
            n_err++; $display("FAIL clear_level: level=%0d ready=%b, required 0/1", level, char_ready);
        end
        cfg_en = 1'b1;
        repeat (30) @(negedge clk);
        n_cmp++; if (frames_seen !== base || tx !== 1'b1) begin
            n_err++; $display("FAIL clear_no_tx: frames=%0d tx=%b, required %0d/1", frames_seen, tx, base);
        end
        push_char(8'h44, 1'b0, 1'b0);
        wait_idle(500);
        n_cmp++; if (frames_seen - base !== 1) begin
            n_err++; $display("FAIL clear_after: got %0d frames, required 1", frames_seen - base);
        end
    endtask

    task automatic test_reset_mid_frame();
        int base = frames_seen;
        int t = 0;
        int bad = 0;
        cfg_en = 1'b1; cfg_div = 16'd3; cfg_bits = 2'd3; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        push_char(8'hC3, 1'b0, 1'b0);
        push_char(8'h5A, 1'b0, 1'b0);
        push_char(8'h7E, 1'b0, 1'b0);
        while (frames_seen == base && t < 500) begin @(negedge clk); t++; end
        n_cmp++; if (frames_seen - base !== 1) begin
            n_err++; $display("FAIL rst_first_frame: got %0d frames, required 1", frames_seen - base);
        end
        repeat (8) @(negedge clk);
        mon_abort = 1'b1;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || level !== 3'd1) begin
            n_err++; $display("FAIL rst_pre: busy=%b level=%0d, required 1/1", busy, level);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (tx !== 1'b1 || level !== 3'd0 || busy !== 1'b0) begin
            n_err++; $display("FAIL rst_mid: tx=%b level=%0d busy=%b, required 1/0/0", tx, level, busy);
        end
        for (int i = 0; i < 60; i++) begin
            if (tx !== 1'b1 || frame_done !== 1'b0) bad++;
            @(negedge clk);
        end
        n_cmp++; if (bad != 0) begin
            n_err++; $display("FAIL rst_idle: %0d cycles with tx low or frame_done high, required 0", bad);
        end
        exp_q.delete();
        mon_abort = 1'b0;
    endtask

`ifdef UART_STIM_ERR_INJ_EN
    task automatic test_err_inject();
        int base = frames_seen;
        cfg_en = 1'b1; cfg_div = 16'd1; cfg_bits = 2'd3; cfg_parity = 2'd2; cfg_stop2 = 1'b0;
        push_char(8'h56, 1'b1, 1'b0);
        push_char(8'h56, 1'b0, 1'b1);
        wait_idle(500);
        n_cmp++; if (frames_seen - base !== 2) begin
            n_err++; $display("FAIL errinj_frames: got %0d, required 2", frames_seen - base);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity_back_to_back(2'd2);
        test_parity_back_to_back(2'd3);
        test_7bit_2stop();
        test_fifo_full();
        test_clear();
        test_reset_mid_frame();
`ifdef UART_STIM_ERR_INJ_EN
        test_err_inject();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
